// File: rtl/byte_mem_ctrl.sv
// byte_mem_ctrl: byte-addressable single-port word memory with per-byte write
// strobes and valid/ready request/response channels. After every reset the
// whole array is walked and cleared before requests are accepted.
// Optional feature macro: MEM_PARITY_EN (per-byte even parity, inject hook and
// parity error flag on read responses).
module byte_mem_ctrl #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned WIDTH  = 32,
    localparam int unsigned NB     = WIDTH / 8,
    localparam int unsigned OFF_W  = $clog2(NB),
    localparam int unsigned IDX_W  = $clog2(DEPTH),
    localparam int unsigned ADDR_W = IDX_W + OFF_W
) (
    input  logic              clk_i,
    input  logic              areset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [WIDTH-1:0]  req_wdata_i,
    input  logic [NB-1:0]     req_be_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WIDTH-1:0]  rsp_rdata_o,
    output logic              rsp_err_o,
`ifdef MEM_PARITY_EN
    input  logic              par_inj_i,
    output logic              par_err_o,
`endif
    output logic              init_done_o
);

    // Offset slice width kept >=1 so the misalignment test elaborates for WIDTH=8
    localparam int unsigned OFF_WS = (OFF_W == 0) ? 1 : OFF_W;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             init_done_d;
    logic             clr_en;
    logic             accept;
    logic             mis;
    logic             wr_en;
    logic             rd_en;
    logic [IDX_W-1:0] idx;

    logic [WIDTH-1:0] mem [DEPTH];

    assign idx         = req_addr_i[ADDR_W-1:OFF_W];
    assign mis         = (OFF_W != 0) && (req_addr_i[OFF_WS-1:0] != '0);
    assign req_ready_o = (state_q == S_RUN) && (!rsp_valid_o || rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign wr_en       = accept && req_we_i && !mis;
    assign rd_en       = accept && !req_we_i && !mis;

    // State, clear counter and init flag registers
    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            init_done_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_o <= init_done_d;
        end
    end

    // Next-state logic: walk every word once, then run until reset
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_o;
        clr_en      = 1'b0;
        case (state_q)
            S_INIT: begin
                clr_en = 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Storage array: clear walk or strobed byte writes (no reset on the array)
    always_ff @(posedge clk_i) begin
        if (clr_en) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (req_be_i[k]) begin
                    mem[idx][8*k +: 8] <= req_wdata_i[8*k +: 8];
                end
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] par_bad;

    // Parity array: zero bytes have even parity 0; inject flips written lanes
    always_ff @(posedge clk_i) begin
        if (clr_en) begin
            par_mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (req_be_i[k]) begin
                    par_mem[idx][k] <= (^req_wdata_i[8*k +: 8]) ^ par_inj_i;
                end
            end
        end
    end

    // Per-lane parity check of the addressed word
    always_comb begin
        par_bad = '0;
        for (int k = 0; k < NB; k++) begin
            par_bad[k] = (^mem[idx][8*k +: 8]) ^ par_mem[idx][k];
        end
    end
`endif

    // Response register: loaded on accept, cleared on transfer without accept
    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
`ifdef MEM_PARITY_EN
            par_err_o   <= 1'b0;
`endif
        end else if (accept) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= mis;
            rsp_rdata_o <= rd_en ? mem[idx] : '0;
`ifdef MEM_PARITY_EN
            par_err_o   <= rd_en && (|par_bad);
`endif
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

endmodule
